// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and helpers for the LIF neuron array
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic RST_ZERO = 1'b0;
  localparam logic RST_SUB  = 1'b1;

  // Neuron index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational leak/integrate/fire step for one neuron
module lif_update
  import lif_pkg::*;
#(
  parameter int IN_W       = 4,
  parameter int STATE_W    = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC_W   = 3
) (
  input  logic [STATE_W-1:0]  v,
  input  logic [REFRAC_W-1:0] r,
  input  logic [IN_W-1:0]     x,
  input  logic [STATE_W-1:0]  threshold,
  input  logic [REFRAC_W-1:0] refrac_cycles,
  input  logic                reset_mode,
  output logic [STATE_W-1:0]  v_next,
  output logic [REFRAC_W-1:0] r_next,
  output logic                spike
);

  logic [STATE_W-1:0] w_leaked;
  logic [STATE_W:0]   w_sum;
  logic [STATE_W-1:0] w_sat;

  // v >> LEAK_SHIFT never exceeds v, so the leak cannot underflow.
  assign w_leaked = v - (v >> LEAK_SHIFT);
  assign w_sum    = {1'b0, w_leaked} + {{(STATE_W + 1 - IN_W){1'b0}}, x};
  assign w_sat    = w_sum[STATE_W] ? {STATE_W{1'b1}} : w_sum[STATE_W-1:0];

  always_comb begin
    v_next = v;
    r_next = r;
    spike  = 1'b0;
    if (r != '0) begin
      r_next = r - REFRAC_W'(1);
    end else if (w_sat >= threshold) begin
      spike  = 1'b1;
      v_next = (reset_mode == RST_SUB) ? (w_sat - threshold) : '0;
      r_next = refrac_cycles;
    end else begin
      v_next = w_sat;
    end
  end

endmodule

// File: rtl/lif_array.sv
// rtl/lif_array.sv - time-multiplexed array of leaky integrate-and-fire neurons
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int IN_W       = 4,
  parameter int STATE_W    = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_NEURONS*IN_W-1:0] in_data,
  input  logic [STATE_W-1:0]        threshold,
  input  logic [REFRAC_W-1:0]       refrac_cycles,
  input  logic                      reset_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_NEURONS-1:0]      spikes
);

  localparam int IDX_W = idx_w(N_NEURONS);

  state_e               r_state;
  state_e               w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [STATE_W-1:0]   r_mem [N_NEURONS];
  logic [REFRAC_W-1:0]  r_ref [N_NEURONS];
  logic [IN_W-1:0]      r_x   [N_NEURONS];
  logic [STATE_W-1:0]   r_thr;
  logic [REFRAC_W-1:0]  r_refc;
  logic                 r_mode;
  logic [N_NEURONS-1:0] r_spikes;

  logic                 w_last;
  logic [STATE_W-1:0]   w_v_next;
  logic [REFRAC_W-1:0]  w_r_next;
  logic                 w_spike;

  assign w_last    = (r_idx == IDX_W'(N_NEURONS - 1));
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign spikes    = r_spikes;

  lif_update #(
    .IN_W       (IN_W),
    .STATE_W    (STATE_W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC_W   (REFRAC_W)
  ) u_update (
    .v             (r_mem[r_idx]),
    .r             (r_ref[r_idx]),
    .x             (r_x[r_idx]),
    .threshold     (r_thr),
    .refrac_cycles (r_refc),
    .reset_mode    (r_mode),
    .v_next        (w_v_next),
    .r_next        (w_r_next),
    .spike         (w_spike)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Config is captured at accept so mid-timestep input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_spikes <= '0;
      r_thr    <= '0;
      r_refc   <= '0;
      r_mode   <= RST_ZERO;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_mem[i] <= '0;
        r_ref[i] <= '0;
        r_x[i]   <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_idx    <= '0;
            r_spikes <= '0;
            r_thr    <= threshold;
            r_refc   <= refrac_cycles;
            r_mode   <= reset_mode;
            for (int i = 0; i < N_NEURONS; i++) r_x[i] <= in_data[i*IN_W +: IN_W];
          end
        end
        ST_RUN: begin
          r_mem[r_idx]    <= w_v_next;
          r_ref[r_idx]    <= w_r_next;
          r_spikes[r_idx] <= w_spike;
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - directed self-checking bench for lif_array
module tb_lif_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [7:0]  threshold = '0;
  logic [2:0]  refrac_cycles = '0;
  logic        reset_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  spikes;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_in_data = '0;
  logic [4:0]  s_threshold = '0;
  logic [2:0]  s_refrac_cycles = '0;
  logic        s_reset_mode = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [3:0]  s_spikes;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lif_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .threshold(threshold), .refrac_cycles(refrac_cycles), .reset_mode(reset_mode),
    .out_valid(out_valid), .out_ready(out_ready), .spikes(spikes)
  );

  lif_array #(.STATE_W(5), .LEAK_SHIFT(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .threshold(s_threshold), .refrac_cycles(s_refrac_cycles), .reset_mode(s_reset_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .spikes(s_spikes)
  );

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // lat counts cycles from the accept cycle (0) to the first cycle with out_valid.
  task automatic step(input logic [15:0] data, input logic [7:0] thr, input logic [2:0] rc,
                      input logic md, output logic [3:0] sp, output int lat);
    in_data = data; threshold = thr; refrac_cycles = rc; reset_mode = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sp = spikes;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic s_step(input logic [15:0] data, input logic [4:0] thr, input logic [2:0] rc,
                        input logic md, output logic [3:0] sp, output int lat);
    s_in_data = data; s_threshold = thr; s_refrac_cycles = rc; s_reset_mode = md; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sp = s_spikes;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] sp;
    int lat;
    do_reset();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (spikes !== 4'b0000) begin n_fail++; $display("FAIL reset_spikes: got %b expected 0000", spikes); end
    step(16'h0000, 8'd1, 3'd0, 1'b0, sp, lat);
    n_tests++; if (sp !== 4'b0000) begin n_fail++; $display("FAIL reset_zero_vec_spikes: got %b expected 0000", sp); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL reset_zero_vec_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_integration();
    logic [7:0] exp_mem [3] = '{8'd15, 8'd29, 8'd41};
    logic [3:0] sp;
    int lat;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(16'hFFFF, 8'd200, 3'd0, 1'b0, sp, lat);
      n_tests++; if (sp !== 4'b0000) begin n_fail++; $display("FAIL integ_spikes step %0d: got %b expected 0000", k, sp); end
      n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL integ_latency step %0d: got %0d expected 5", k, lat); end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (dut.r_mem[i] !== exp_mem[k]) begin
          n_fail++; $display("FAIL integ_mem step %0d ch %0d: got %0d expected %0d", k, i, dut.r_mem[i], exp_mem[k]);
        end
      end
    end
  endtask

  task automatic test_refractory();
    logic [3:0] exp_sp  [2][5] = '{'{4'h0, 4'h1, 4'h0, 4'h0, 4'h0}, '{4'h0, 4'h1, 4'h0, 4'h0, 4'h1}};
    logic [7:0] exp_mem [2][5] = '{'{8'd15, 8'd0, 8'd0, 8'd0, 8'd15}, '{8'd15, 8'd9, 8'd9, 8'd9, 8'd3}};
    logic [3:0] sp;
    int lat;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      for (int k = 0; k < 5; k++) begin
        step(16'h000F, 8'd20, 3'd2, m[0], sp, lat);
        n_tests++; if (sp !== exp_sp[m][k]) begin n_fail++; $display("FAIL refrac_spikes mode %0d step %0d: got %b expected %b", m, k + 1, sp, exp_sp[m][k]); end
        n_tests++; if (dut.r_mem[0] !== exp_mem[m][k]) begin n_fail++; $display("FAIL refrac_mem mode %0d step %0d: got %0d expected %0d", m, k + 1, dut.r_mem[0], exp_mem[m][k]); end
      end
      n_tests++; if (dut.r_mem[1] !== 8'd0) begin n_fail++; $display("FAIL refrac_idle_ch mode %0d: got %0d expected 0", m, dut.r_mem[1]); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_sp  [3] = '{4'h0, 4'h0, 4'hF};
    logic [4:0] exp_mem [3] = '{5'd15, 5'd30, 5'd0};
    logic [3:0] sp;
    int lat;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      s_step(16'hFFFF, 5'd31, 3'd0, 1'b1, sp, lat);
      n_tests++; if (sp !== exp_sp[k]) begin n_fail++; $display("FAIL sat_spikes step %0d: got %b expected %b", k + 1, sp, exp_sp[k]); end
      n_tests++; if (dut_s.r_mem[3] !== exp_mem[k]) begin n_fail++; $display("FAIL sat_mem step %0d: got %0d expected %0d", k + 1, dut_s.r_mem[3], exp_mem[k]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    in_data = 16'hFFFF; threshold = 8'd0; refrac_cycles = 3'd0; reset_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d expected 5", lat); end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 16'h0000; threshold = 8'd200;
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc %0d: got %b expected 1", c, out_valid); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b expected 0", c, in_ready); end
      n_tests++; if (spikes !== 4'hF) begin n_fail++; $display("FAIL bp_spikes cyc %0d: got %b expected 1111", c, spikes); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept_at_handoff: got %b expected 1", in_ready); end
    n_tests++; if (dut.r_mem[2] !== 8'd0) begin n_fail++; $display("FAIL bp_mem: got %0d expected 0", dut.r_mem[2]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] sp;
    int lat;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(16'h1234, 8'd0, 3'd0, 1'b1, sp, lat);
      n_tests++; if (sp !== 4'hF) begin n_fail++; $display("FAIL b2b_spikes step %0d: got %b expected 1111", k, sp); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] sp;
    int lat;
    do_reset();
    in_data = 16'hFFFF; threshold = 8'd200; refrac_cycles = 3'd0; reset_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (dut.r_idx !== 2'd2) begin n_fail++; $display("FAIL midrst_idx: got %0d expected 2", dut.r_idx); end
    n_tests++; if (dut.r_mem[0] !== 8'd15) begin n_fail++; $display("FAIL midrst_progress: got %0d expected 15", dut.r_mem[0]); end
    do_reset();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (dut.r_mem[i] !== 8'd0) begin n_fail++; $display("FAIL midrst_mem ch %0d: got %0d expected 0", i, dut.r_mem[i]); end
    end
    step(16'hFFFF, 8'd200, 3'd0, 1'b0, sp, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_after_latency: got %0d expected 5", lat); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (dut.r_mem[i] !== 8'd15) begin n_fail++; $display("FAIL midrst_after_mem ch %0d: got %0d expected 15", i, dut.r_mem[i]); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_integration();
    test_refractory();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
